// File: rtl/imem_arbiter.sv
// Two-requester arbiter for the single-port, synchronous-read instruction memory.
// Grants are combinational; read data returns to the granted requester one cycle later.
module imem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned MAX_WAIT   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [7:0] MaxWaitCnt = 8'(MAX_WAIT);

  logic              last_gnt_q, last_gnt_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic [1:0]        resp_owner_q, resp_owner_d;

  // Grant decision; nothing is granted while in reset.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!rst) begin
      if (m0_req && m1_req) begin
        if (FIXED_PRIO == 0) begin
          if (last_gnt_q) m0_gnt = 1'b1;
          else            m1_gnt = 1'b1;
        end else begin
          if (wait_cnt_q == MaxWaitCnt) m0_gnt = 1'b1;
          else                          m1_gnt = 1'b1;
        end
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  // Idle cycles replay the last granted address to keep the memory bus quiet.
  always_comb begin
    if (m0_gnt)      mem_addr = m0_addr;
    else if (m1_gnt) mem_addr = m1_addr;
    else             mem_addr = addr_hold_q;
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (m1_gnt)      last_gnt_d = 1'b1;
    else if (m0_gnt) last_gnt_d = 1'b0;

    wait_cnt_d = wait_cnt_q;
    if (!m0_req || m0_gnt)       wait_cnt_d = 8'd0;
    else if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;

    addr_hold_d  = (m0_gnt || m1_gnt) ? mem_addr : addr_hold_q;
    resp_owner_d = {m1_gnt, m0_gnt};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q   <= 1'b1;
      wait_cnt_q   <= 8'd0;
      addr_hold_q  <= '0;
      resp_owner_q <= 2'b00;
    end else begin
      last_gnt_q   <= last_gnt_d;
      wait_cnt_q   <= wait_cnt_d;
      addr_hold_q  <= addr_hold_d;
      resp_owner_q <= resp_owner_d;
    end
  end

  always_comb begin
    m0_rvalid = resp_owner_q[0];
    m1_rvalid = resp_owner_q[1];
    m0_rdata  = m0_rvalid ? mem_rdata : '0;
    m1_rdata  = m1_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority (MAX_WAIT=3) instance share stimulus.
// Expected responses are queued at grant time and compared when rvalid is due.
module tb_imem_arbiter;

  typedef struct packed {
    logic [1:0]  own;
    logic [31:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr;

  logic        rr_m0_gnt, rr_m1_gnt, rr_m0_rvalid, rr_m1_rvalid;
  logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_mem_addr, rr_mem_rdata;
  logic        fp_m0_gnt, fp_m1_gnt, fp_m0_rvalid, fp_m1_rvalid;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_mem_addr, fp_mem_rdata;

  int    n_checks = 0;
  int    n_pass   = 0;
  resp_t sb[$];

  always #5 clk = ~clk;

  imem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0), .MAX_WAIT(8)) dut_rr (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(rr_m0_gnt),
    .m0_rvalid(rr_m0_rvalid), .m0_rdata(rr_m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(rr_m1_gnt),
    .m1_rvalid(rr_m1_rvalid), .m1_rdata(rr_m1_rdata),
    .mem_addr(rr_mem_addr), .mem_rdata(rr_mem_rdata)
  );

  imem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1), .MAX_WAIT(3)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(fp_m0_gnt),
    .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(fp_m1_gnt),
    .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata),
    .mem_addr(fp_mem_addr), .mem_rdata(fp_mem_rdata)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // Synchronous-read memory models, one per instance.
  always @(posedge clk) begin
    rr_mem_rdata <= mem_word(rr_mem_addr);
    fp_mem_rdata <= mem_word(fp_mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock: sample at negedge, then advance to just after the next posedge.
  task automatic cyc(input logic eg0, input logic eg1, input logic chk_addr,
                     input logic [31:0] eaddr, input logic chk_fp,
                     input logic fg0, input logic fg1);
    resp_t e;
    @(negedge clk);
    chk("rr_m0_gnt", 32'(rr_m0_gnt), 32'(eg0));
    chk("rr_m1_gnt", 32'(rr_m1_gnt), 32'(eg1));
    if (chk_addr) chk("rr_mem_addr", rr_mem_addr, eaddr);
    if (chk_fp) begin
      chk("fp_m0_gnt", 32'(fp_m0_gnt), 32'(fg0));
      chk("fp_m1_gnt", 32'(fp_m1_gnt), 32'(fg1));
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rr_m0_rvalid", 32'(rr_m0_rvalid), 32'(e.own[0]));
      chk("rr_m1_rvalid", 32'(rr_m1_rvalid), 32'(e.own[1]));
      chk("rr_m0_rdata", rr_m0_rdata, e.own[0] ? e.data : 32'h0);
      chk("rr_m1_rdata", rr_m1_rdata, e.own[1] ? e.data : 32'h0);
    end
    e.own  = {eg1, eg0};
    e.data = mem_word(eaddr);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with both requests pending: grants must stay low.
    rst = 1'b1; m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h0; m1_addr = 32'h100;
    cyc(0, 0, 0, 32'h0, 1, 0, 0);
    cyc(0, 0, 0, 32'h0, 1, 0, 0);
    chk("rst_fp_m0_rvalid", 32'(fp_m0_rvalid), 32'h0);
    chk("rst_fp_m1_rdata", fp_m1_rdata, 32'h0);

    // Continuous conflict: round-robin alternates from m0, fixed-priority runs 3:1.
    rst = 1'b0;
    for (int i = 0; i < 8; i++)
      cyc(i % 2 == 0, i % 2 == 1, 1, (i % 2 == 0) ? 32'h0 : 32'h100,
          1, i % 4 == 3, i % 4 != 3);

    // Single m0 read of 0xDEADBEEF.
    m1_req = 1'b0; m0_addr = 32'h10;
    cyc(1, 0, 1, 32'h10, 1, 1, 0);
    m0_req = 1'b0;
    cyc(0, 0, 1, 32'h10, 0, 0, 0);

    // Back-to-back streaming from m0.
    m0_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m0_addr = 32'(i * 4);
      cyc(1, 0, 1, 32'(i * 4), 0, 0, 0);
    end

    // Idle hold after a grant to 0x20.
    m0_addr = 32'h20;
    cyc(1, 0, 1, 32'h20, 0, 0, 0);
    m0_req = 1'b0;
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 32'h20, 0, 0, 0);

    // Reset while m1 requests 0x40: no grant, no response; m0 then wins the conflict.
    rst = 1'b1; m1_req = 1'b1; m1_addr = 32'h40;
    cyc(0, 0, 0, 32'h0, 1, 0, 0);
    rst = 1'b0; m0_req = 1'b1; m0_addr = 32'h44;
    cyc(1, 0, 1, 32'h44, 0, 0, 0);
    m0_req = 1'b0;
    cyc(0, 1, 1, 32'h40, 1, 0, 1);
    m1_req = 1'b0;
    cyc(0, 0, 1, 32'h40, 0, 0, 0);
    cyc(0, 0, 1, 32'h40, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
